player_status_manager: RTL and testbench

PLAYER_STATUS_MANAGER -- requirements
Module: player_status_manager

---
 rtl/game_pkg.sv | 20 ++
 rtl/bcd_counter4.sv | 46 ++++
 rtl/player_status_manager.sv | 179 +++++++++++++++++
 tb/tb_player_status_manager.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the player status logic: the status FSM state type and
// the default frame-timing constants used as parameter defaults.
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_DYING     = 2'd1,
        ST_INVULN    = 2'd2,
        ST_GAME_OVER = 2'd3
    } player_state_t;

    localparam int DEF_INIT_LIVES    = 3;
    localparam int DEF_DEATH_FRAMES  = 30;
    localparam int DEF_INVULN_FRAMES = 60;
    localparam int DEF_BLINK_FRAMES  = 4;

endpackage

// File: rtl/bcd_counter4.sv
// -----------------------------------------------------------------------------
// bcd_counter4
// Four-digit BCD up-counter that sticks at 9999.
//   clk    : system clock
//   resetN : asynchronous active-low reset (count -> 0000)
//   clear  : synchronous clear, wins over inc
//   inc    : add one with decimal carry (ignored at 9999)
//   count  : four BCD digits, [15:12] thousands
// -----------------------------------------------------------------------------
module bcd_counter4 (
    input  logic        clk,
    input  logic        resetN,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] inc_val;
    logic        carry;

    always_comb begin
        inc_val = count;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (inc_val[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = inc_val[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= 16'h0000;
        end else if (clear) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'h9999)) begin
            count <= inc_val;
        end
    end

endmodule

// File: rtl/player_status_manager.sv
// -----------------------------------------------------------------------------
// player_status_manager
// Tracks lives, score and the death / respawn / invulnerability sequence.
//   clk                    : system clock
//   resetN                 : asynchronous active-low reset
//   startOfFrame           : one pulse per frame, time base for frame counters
//   SingleHitPulse_player  : player was hit
//   SingleHitPulse_enemies : an enemy was destroyed (score +1)
//   restart                : key level, rising edge restarts after game over
//   lives                  : remaining lives
//   score_bcd              : four-digit BCD score
//   player_visible         : draw enable (blinks while invulnerable)
//   invulnerable           : high in DYING and INVULN
//   respawn_pulse          : one-cycle request to return player to start tile
//   game_over              : high in GAME_OVER
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_PLAY      | normal play, hits cost a life
// ST_DYING     | death animation, counts DEATH_FRAMES frames, player hidden
// ST_INVULN    | after respawn, counts INVULN_FRAMES frames, player blinks
// ST_GAME_OVER | no lives left, waits for restart edge
// -----------------------------------------------------------------------------
module player_status_manager
    import game_pkg::*;
#(
    parameter int INIT_LIVES    = DEF_INIT_LIVES,
    parameter int DEATH_FRAMES  = DEF_DEATH_FRAMES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        SingleHitPulse_player,
    input  logic        SingleHitPulse_enemies,
    input  logic        restart,
    output logic [1:0]  lives,
    output logic [15:0] score_bcd,
    output logic        player_visible,
    output logic        invulnerable,
    output logic        respawn_pulse,
    output logic        game_over
);

    localparam int MAX_FRAMES = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
    localparam int BLK_W      = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0] DEATH_CNT  = CNT_W'(DEATH_FRAMES);
    localparam logic [CNT_W-1:0] INVULN_CNT = CNT_W'(INVULN_FRAMES);
    localparam logic [BLK_W-1:0] BLINK_CNT  = BLK_W'(BLINK_FRAMES);
    localparam logic [1:0]       INIT_L     = 2'(INIT_LIVES);

    player_state_t    state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [1:0]       lives_d;
    logic             visible_d;
    logic             respawn_d;
    logic             restart_q;
    logic             restart_rise;
    logic             frame_last;
    logic             blink_last;
    logic             score_clr;
    logic             score_inc;

    assign restart_rise = restart & ~restart_q;
    assign frame_last   = startOfFrame && (frame_cnt_q == CNT_W'(1));
    assign blink_last   = (blink_cnt_q == BLK_W'(1));
    assign score_inc    = SingleHitPulse_enemies && (state_q != ST_GAME_OVER);

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        lives_d     = lives;
        visible_d   = player_visible;
        respawn_d   = 1'b0;
        score_clr   = 1'b0;

        case (state_q)
            ST_PLAY: begin
                visible_d = 1'b1;
                // A frame pulse in the same cycle is deliberately not applied
                // to the freshly loaded death counter.
                if (SingleHitPulse_player) begin
                    lives_d   = lives - 2'd1;
                    visible_d = 1'b0;
                    if (lives <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d     = ST_DYING;
                        frame_cnt_d = DEATH_CNT;
                    end
                end
            end

            ST_DYING: begin
                if (frame_last) begin
                    state_d     = ST_INVULN;
                    frame_cnt_d = INVULN_CNT;
                    blink_cnt_d = BLINK_CNT;
                    visible_d   = 1'b1;
                    respawn_d   = 1'b1;
                end else if (startOfFrame) begin
                    frame_cnt_d = frame_cnt_q - CNT_W'(1);
                end
            end

            ST_INVULN: begin
                if (frame_last) begin
                    state_d     = ST_PLAY;
                    frame_cnt_d = '0;
                    visible_d   = 1'b1;
                end else if (startOfFrame) begin
                    frame_cnt_d = frame_cnt_q - CNT_W'(1);
                    if (blink_last) begin
                        blink_cnt_d = BLINK_CNT;
                        visible_d   = ~player_visible;
                    end else begin
                        blink_cnt_d = blink_cnt_q - BLK_W'(1);
                    end
                end
            end

            ST_GAME_OVER: begin
                visible_d = 1'b0;
                if (restart_rise) begin
                    lives_d     = INIT_L;
                    score_clr   = 1'b1;
                    state_d     = ST_INVULN;
                    frame_cnt_d = INVULN_CNT;
                    blink_cnt_d = BLINK_CNT;
                    visible_d   = 1'b1;
                    respawn_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= ST_PLAY;
            frame_cnt_q    <= '0;
            blink_cnt_q    <= '0;
            lives          <= INIT_L;
            player_visible <= 1'b1;
            invulnerable   <= 1'b0;
            respawn_pulse  <= 1'b0;
            game_over      <= 1'b0;
            restart_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            lives          <= lives_d;
            player_visible <= visible_d;
            invulnerable   <= (state_d == ST_DYING) || (state_d == ST_INVULN);
            respawn_pulse  <= respawn_d;
            game_over      <= (state_d == ST_GAME_OVER);
            restart_q      <= restart;
        end
    end

    bcd_counter4 u_score (
        .clk    (clk),
        .resetN (resetN),
        .clear  (score_clr),
        .inc    (score_inc),
        .count  (score_bcd)
    );

endmodule

// File: tb/tb_player_status_manager.sv
module tb_player_status_manager;

    localparam int INIT = 3;
    localparam int DF   = 30;
    localparam int IVF  = 60;
    localparam int BF   = 4;

    localparam int MP = 0;  // playing
    localparam int MD = 1;  // dying
    localparam int MI = 2;  // invulnerable
    localparam int MO = 3;  // game over

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sof = 1'b0;
    logic        hit = 1'b0;
    logic        enemy = 1'b0;
    logic        restart = 1'b0;
    logic [1:0]  lives;
    logic [15:0] score_bcd;
    logic        player_visible;
    logic        invulnerable;
    logic        respawn_pulse;
    logic        game_over;

    int n_cmp = 0;
    int n_err = 0;
    int resp_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    player_status_manager #(
        .INIT_LIVES    (INIT),
        .DEATH_FRAMES  (DF),
        .INVULN_FRAMES (IVF),
        .BLINK_FRAMES  (BF)
    ) dut (
        .clk                    (clk),
        .resetN                 (resetN),
        .startOfFrame           (sof),
        .SingleHitPulse_player  (hit),
        .SingleHitPulse_enemies (enemy),
        .restart                (restart),
        .lives                  (lives),
        .score_bcd              (score_bcd),
        .player_visible         (player_visible),
        .invulnerable           (invulnerable),
        .respawn_pulse          (respawn_pulse),
        .game_over              (game_over)
    );

    // ---------------- behavioural model ----------------
    int m_mode, m_lives, m_score, m_frames, m_pulses;
    bit m_resp, m_rprev;

    task automatic m_reset();
        m_mode = MP; m_lives = INIT; m_score = 0; m_frames = 0;
        m_pulses = 0; m_resp = 0; m_rprev = 0;
    endtask

    task automatic m_step();
        bit rise;
        rise    = restart && !m_rprev;
        m_rprev = restart;
        m_resp  = 0;
        if (enemy && m_mode != MO && m_score < 9999) m_score++;
        case (m_mode)
            MP: if (hit) begin
                m_lives--;
                if (m_lives == 0) m_mode = MO;
                else begin m_mode = MD; m_frames = DF; end
            end
            MD: if (sof) begin
                m_frames--;
                if (m_frames == 0) begin
                    m_mode = MI; m_frames = IVF; m_pulses = 0; m_resp = 1;
                end
            end
            MI: if (sof) begin
                m_frames--;
                m_pulses++;
                if (m_frames == 0) m_mode = MP;
            end
            default: if (rise) begin
                m_lives = INIT; m_score = 0; m_mode = MI;
                m_frames = IVF; m_pulses = 0; m_resp = 1;
            end
        endcase
    endtask

    function automatic logic exp_vis();
        if (m_mode == MP) return 1'b1;
        if (m_mode == MI) return ((m_pulses / BF) % 2) == 0;
        return 1'b0;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) m_reset();
            else m_step();
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (respawn_pulse === 1'b1) resp_cnt++;
            if (chk_en) begin
                check("model_lives", 16'(lives), 16'(m_lives));
                check("model_score", score_bcd, to_bcd(m_score));
                check("model_visible", 16'(player_visible), 16'(exp_vis()));
                check("model_invuln", 16'(invulnerable), 16'((m_mode == MD) || (m_mode == MI)));
                check("model_respawn", 16'(respawn_pulse), 16'(m_resp));
                check("model_game_over", 16'(game_over), 16'(m_mode == MO));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit h, input bit e, input bit s);
        @(negedge clk);
        hit = h; enemy = e; sof = s;
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick(0, 0, 1);
            tick(0, 0, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        hit = 0; enemy = 0; sof = 0;
        #2 resetN = 1'b0;
        #1;
        check("rst_lives", 16'(lives), 16'(INIT));
        check("rst_respawn", 16'(respawn_pulse), 16'd0);
        check("rst_invuln", 16'(invulnerable), 16'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        int r0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        resetN = 1'b1;
        #1;
        check("reset_lives", 16'(lives), 16'd3);
        check("reset_score", score_bcd, 16'h0000);
        check("reset_visible", 16'(player_visible), 16'd1);
        check("reset_go", 16'(game_over), 16'd0);

        // first hit
        tick(1, 0, 0);
        check("hit1_lives", 16'(lives), 16'd2);
        check("hit1_visible", 16'(player_visible), 16'd0);
        check("hit1_invuln", 16'(invulnerable), 16'd1);
        tick(0, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        check("dying_hit_ignored", 16'(lives), 16'd2);

        // death timing
        r0 = resp_cnt;
        for (int i = 1; i <= DF; i++) begin
            tick(0, 0, 1);
            if (i == DF - 1) check("no_respawn_29", 16'(respawn_pulse), 16'd0);
            if (i == DF) check("respawn_on_30", 16'(respawn_pulse), 16'd1);
            tick(0, 0, 0);
        end
        check("single_respawn", 16'(resp_cnt - r0), 16'd1);
        tick(1, 0, 0);
        tick(0, 0, 0);
        check("invuln_hit_ignored", 16'(lives), 16'd2);
        for (int k = 1; k <= IVF; k++) begin
            tick(0, 0, 1);
            if (k == 3) check("blink_k3", 16'(player_visible), 16'd1);
            if (k == 4) check("blink_k4", 16'(player_visible), 16'd0);
            if (k == 8) check("blink_k8", 16'(player_visible), 16'd1);
            if (k == IVF) check("back_to_play", 16'(invulnerable), 16'd0);
            tick(0, 0, 0);
        end

        // deaths two and three, plus some score
        tick(1, 0, 0);
        frames(DF);
        frames(IVF);
        repeat (3) tick(0, 1, 0);
        tick(1, 0, 0);
        check("dead_lives", 16'(lives), 16'd0);
        check("dead_go", 16'(game_over), 16'd1);
        repeat (5) tick(0, 1, 0);
        tick(0, 0, 0);
        check("go_score_frozen", score_bcd, 16'h0003);

        // held restart
        r0 = resp_cnt;
        @(negedge clk);
        restart = 1'b1;
        repeat (100) tick(0, 0, 0);
        restart = 1'b0;
        tick(0, 0, 0);
        check("restart_once", 16'(resp_cnt - r0), 16'd1);
        check("restart_lives", 16'(lives), 16'd3);
        check("restart_score", score_bcd, 16'h0000);
        check("restart_go", 16'(game_over), 16'd0);

        // score carry and saturation
        do_reset();
        repeat (99) tick(0, 1, 0);
        check("score_0099", score_bcd, 16'h0099);
        tick(0, 1, 0);
        check("score_0100", score_bcd, 16'h0100);
        repeat (9899) tick(0, 1, 0);
        check("score_9999", score_bcd, 16'h9999);
        tick(0, 1, 0);
        tick(0, 0, 0);
        check("score_sat", score_bcd, 16'h9999);

        // simultaneous hit and enemy
        do_reset();
        repeat (41) tick(0, 1, 0);
        tick(1, 1, 0);
        check("simul_score", score_bcd, 16'h0042);
        check("simul_lives", 16'(lives), 16'd2);
        check("simul_dying", 16'(invulnerable), 16'd1);

        // hit coincident with frame pulse
        do_reset();
        tick(1, 0, 1);
        r0 = resp_cnt;
        tick(0, 0, 0);
        frames(DF - 1);
        check("hitsof_no_early", 16'(resp_cnt - r0), 16'd0);
        frames(1);
        check("hitsof_respawn", 16'(resp_cnt - r0), 16'd1);

        // reset mid-dying
        do_reset();
        tick(1, 0, 0);
        frames(10);
        r0 = resp_cnt;
        do_reset();
        repeat (5) tick(0, 0, 0);
        check("abort_no_respawn", 16'(resp_cnt - r0), 16'd0);
        check("abort_lives", 16'(lives), 16'd3);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 24) == 0) restart = ~restart;
            if ($urandom_range(0, 1999) == 0) do_reset();
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
        end
        tick(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
